eip_ctrl: RTL

External-interrupt controller that aggregates up to NSRC device interrupt lines into the single `m_eip` / `m_eip_reply` pair consumed by the CSR/privilege unit. It keeps per-source pending, enable and trigger-mode state, which M-mode software accesses over the MMIO bus. It selects one source at a time by fixed priority, with the lowest index winning. Software then uses a claim/complete handshake to read which source fired and to release the controller for the next one.

---
 rtl/eip_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/eip_ctrl.sv
// External-interrupt controller: per-source pending/enable/trigger state,
// fixed-priority selection and a claim/complete handshake toward M-mode.
module eip_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [2:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    output logic            m_eip,
    input  logic            m_eip_reply
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ASSERT  = 2'b01,
        S_SERVICE = 2'b10,
        S_BAD     = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] trigger_q, trigger_d;
    logic [NSRC-1:0] src_q;
    logic [4:0]      claim_id_q, claim_id_d;
    logic            m_eip_q, m_eip_d;

    logic [NSRC-1:0] req;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] w1c_mask;
    logic [NSRC-1:0] done_mask;
    logic [4:0]      low_idx;
    logic [4:0]      claim_tag;
    logic            complete;
    logic            unused_d;

    assign unused_d  = ^d;
    assign req       = pending_q & enable_q;
    assign edge_set  = irq_src & ~src_q;
    assign claim_tag = claim_id_q + 5'd1;
    assign complete  = we && (a == 3'd3) && (state_q == S_SERVICE)
                       && (d[4:0] == claim_tag);
    assign w1c_mask  = (we && a == 3'd0) ? d[NSRC-1:0] : '0;
    assign done_mask = complete ? (NSRC'(1) << claim_id_q) : '0;
    assign m_eip     = m_eip_q;

    // Scan high to low so the lowest set index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) low_idx = 5'(i);
        end
    end

    always_comb begin
        enable_d  = enable_q;
        trigger_d = trigger_q;
        if (we && a == 3'd1) enable_d  = d[NSRC-1:0];
        if (we && a == 3'd2) trigger_d = d[NSRC-1:0];
    end

    // Edge sources: new edge beats a same-cycle clear. Level sources track the line.
    always_comb begin
        pending_d = (trigger_q & (((pending_q & ~(w1c_mask | done_mask))) | edge_set))
                  | (~trigger_q & irq_src);
    end

    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        m_eip_d    = m_eip_q;
        unique case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    claim_id_d = low_idx;
                    m_eip_d    = 1'b1;
                    state_d    = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (m_eip_reply) begin
                    m_eip_d = 1'b0;
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (complete) state_d = S_IDLE;
            end
            default: begin
                m_eip_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            enable_q   <= '0;
            trigger_q  <= '0;
            src_q      <= '0;
            claim_id_q <= '0;
            m_eip_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            trigger_q  <= trigger_d;
            src_q      <= irq_src;
            claim_id_q <= claim_id_d;
            m_eip_q    <= m_eip_d;
        end
    end

    always_comb begin
        spo = '0;
        case (a)
            3'd0: spo = {{(32-NSRC){1'b0}}, pending_q};
            3'd1: spo = {{(32-NSRC){1'b0}}, enable_q};
            3'd2: spo = {{(32-NSRC){1'b0}}, trigger_q};
            3'd3: spo = (state_q == S_SERVICE) ? {27'b0, claim_tag} : '0;
            3'd4: spo = {30'b0, state_q};
            default: spo = '0;
        endcase
    end

endmodule
